cafeteira_arbitro_sensor: RTL and testbench

//  Shares the single ultrasonic ranging interface between the water-level and cup-detect requesters.

---
 rtl/cafeteira_arbitro_sensor.sv | 166 ++++++++++++++++
 tb/tb_cafeteira_arbitro_sensor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cafeteira_arbitro_sensor.sv
// Purpose: arbitrates the shared ultrasonic ranger between water-level and cup-detect requesters, with timeout retries.
// Latency: trigger one cycle after a request is sampled in OCIOSO; done/erro one cycle after pronto or final timeout.
// Backpressure: requests are level signals sampled only in OCIOSO; a grant runs to done/erro, then a guard gap follows.
// Option: define CAFETEIRA_ARB_PRIO_AGUA_EN for fixed water priority; the default is round robin.
module cafeteira_arbitro_sensor #(
  parameter int MED_W          = 12,
  parameter int CONT_W         = 22,
  parameter int TIMEOUT_CICLOS = 1_500_000,
  parameter int GUARD_CICLOS   = 3_000_000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_agua,
  input  logic             req_xicara,
  input  logic             sensor_pronto,
  input  logic [MED_W-1:0] sensor_medida,
  output logic             sensor_medir,
  output logic             sensor_sel,
  output logic [MED_W-1:0] medida,
  output logic             done_agua,
  output logic             done_xicara,
  output logic             erro_agua,
  output logic             erro_xicara,
  output logic             ocupado,
  output logic [2:0]       db_estado
);

  localparam int TW = (MAX_TENTATIVAS > 1) ? $clog2(MAX_TENTATIVAS) : 1;
  localparam logic [CONT_W-1:0] TO_ULT   = CONT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [CONT_W-1:0] GD_ULT   = CONT_W'(GUARD_CICLOS - 1);
  localparam logic [TW-1:0]     TENT_ULT = TW'(MAX_TENTATIVAS - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    DISPARA = 3'd1,
    ESPERA  = 3'd2,
    ENTREGA = 3'd3,
    ERRO    = 3'd4,
    GUARDA  = 3'd5
  } estado_t;

  estado_t          estado, estado_nxt;
  logic [CONT_W-1:0] cont, cont_nxt;
  logic [TW-1:0]     tent, tent_nxt;
  logic              retry, retry_nxt;
  logic              ultimo, ultimo_nxt;   // 0 = water served last, 1 = cup
  logic              sel, sel_nxt;
  logic [MED_W-1:0]  med, med_nxt;
  logic              grant_sel;

  // Choose which requester wins when a grant is made (only meaningful in OCIOSO)
  always_comb begin
`ifdef CAFETEIRA_ARB_PRIO_AGUA_EN
    grant_sel = ~req_agua;
`else
    if (req_agua && req_xicara) begin
      grant_sel = ~ultimo;
    end else begin
      grant_sel = ~req_agua;
    end
`endif
  end

  // Next-state, datapath next values and Moore outputs
  always_comb begin
    estado_nxt   = estado;
    cont_nxt     = cont;
    tent_nxt     = tent;
    retry_nxt    = retry;
    ultimo_nxt   = ultimo;
    sel_nxt      = sel;
    med_nxt      = med;
    sensor_medir = 1'b0;
    done_agua    = 1'b0;
    done_xicara  = 1'b0;
    erro_agua    = 1'b0;
    erro_xicara  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (req_agua || req_xicara) begin
          sel_nxt    = grant_sel;
          tent_nxt   = '0;
          estado_nxt = DISPARA;
        end
      end
      DISPARA: begin
        sensor_medir = 1'b1;
        cont_nxt     = '0;
        estado_nxt   = ESPERA;
      end
      ESPERA: begin
        cont_nxt = cont + 1'b1;
        // A pronto arriving on the timeout cycle still counts as a success
        if (sensor_pronto) begin
          med_nxt    = sensor_medida;
          estado_nxt = ENTREGA;
        end else if (cont == TO_ULT) begin
          if (tent == TENT_ULT) begin
            estado_nxt = ERRO;
          end else begin
            tent_nxt   = tent + 1'b1;
            retry_nxt  = 1'b1;
            cont_nxt   = '0;
            estado_nxt = GUARDA;
          end
        end
      end
      ENTREGA: begin
        done_agua   = ~sel;
        done_xicara = sel;
        ultimo_nxt  = sel;
        retry_nxt   = 1'b0;
        cont_nxt    = '0;
        estado_nxt  = GUARDA;
      end
      ERRO: begin
        erro_agua   = ~sel;
        erro_xicara = sel;
        ultimo_nxt  = sel;
        retry_nxt   = 1'b0;
        cont_nxt    = '0;
        estado_nxt  = GUARDA;
      end
      GUARDA: begin
        // The echo must settle before the next trigger, retry or not
        if (cont == GD_ULT) begin
          cont_nxt   = '0;
          estado_nxt = retry ? DISPARA : OCIOSO;
        end else begin
          cont_nxt = cont + 1'b1;
        end
      end
      default: begin
        estado_nxt = OCIOSO;
      end
    endcase
  end

  // State and datapath registers; reset drops any grant in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      cont   <= '0;
      tent   <= '0;
      retry  <= 1'b0;
      ultimo <= 1'b1;
      sel    <= 1'b0;
      med    <= '0;
    end else begin
      estado <= estado_nxt;
      cont   <= cont_nxt;
      tent   <= tent_nxt;
      retry  <= retry_nxt;
      ultimo <= ultimo_nxt;
      sel    <= sel_nxt;
      med    <= med_nxt;
    end
  end

  assign sensor_sel = sel;
  assign medida     = med;
  assign ocupado    = (estado != OCIOSO);
  assign db_estado  = estado;

endmodule

// File: tb/tb_cafeteira_arbitro_sensor.sv
// Purpose: self-checking bench for cafeteira_arbitro_sensor with short timeout/guard values.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: requests are dropped by the bench after done/erro unless a hold-high round is being run.
module tb_cafeteira_arbitro_sensor;

  localparam int MED_W = 12;
  localparam int TO    = 20;
  localparam int GD    = 5;
  localparam int MT    = 3;

  logic             clock;
  logic             reset;
  logic             req_agua;
  logic             req_xicara;
  logic             sensor_pronto;
  logic [MED_W-1:0] sensor_medida;
  logic             sensor_medir;
  logic             sensor_sel;
  logic [MED_W-1:0] medida;
  logic             done_agua;
  logic             done_xicara;
  logic             erro_agua;
  logic             erro_xicara;
  logic             ocupado;
  logic [2:0]       db_estado;

  cafeteira_arbitro_sensor #(
    .MED_W(MED_W), .CONT_W(22), .TIMEOUT_CICLOS(TO), .GUARD_CICLOS(GD), .MAX_TENTATIVAS(MT)
  ) dut (
    .clock(clock), .reset(reset), .req_agua(req_agua), .req_xicara(req_xicara),
    .sensor_pronto(sensor_pronto), .sensor_medida(sensor_medida),
    .sensor_medir(sensor_medir), .sensor_sel(sensor_sel), .medida(medida),
    .done_agua(done_agua), .done_xicara(done_xicara),
    .erro_agua(erro_agua), .erro_xicara(erro_xicara),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Event log filled by run()
  int   cyc, pend, resp_delay;
  bit   answer, auto_drop;
  int   n_trig, n_da, n_dx, n_ea, n_ex;
  int   da_cyc, dx_cyc, ex_cyc;
  int   trig_cyc [8];
  logic trig_sel [8];

  task automatic clear_log;
    cyc = 0; pend = -1;
    n_trig = 0; n_da = 0; n_dx = 0; n_ea = 0; n_ex = 0;
    da_cyc = -1; dx_cyc = -1; ex_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      trig_cyc[i] = -1;
      trig_sel[i] = 1'bx;
    end
  endtask

  // Runs n cycles, answering each trigger resp_delay cycles later when enabled
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sensor_pronto = answer && (cyc == pend);
      sensor_medida = 12'h155;
      tick;
      cyc++;
      if (sensor_medir) begin
        if (n_trig < 8) begin
          trig_cyc[n_trig] = cyc;
          trig_sel[n_trig] = sensor_sel;
        end
        n_trig++;
        pend = cyc + resp_delay;
      end
      if (done_agua)   begin n_da++; da_cyc = cyc; if (auto_drop) req_agua = 1'b0; end
      if (erro_agua)   begin n_ea++;               if (auto_drop) req_agua = 1'b0; end
      if (done_xicara) begin n_dx++; dx_cyc = cyc; if (auto_drop) req_xicara = 1'b0; end
      if (erro_xicara) begin n_ex++; ex_cyc = cyc; if (auto_drop) req_xicara = 1'b0; end
    end
    sensor_pronto = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req_agua = 1'b0; req_xicara = 1'b0; sensor_pronto = 1'b0; sensor_medida = '0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  typedef struct {
    logic       ra, rx, pr;
    logic [11:0] mi;
    logic [2:0] st;
    logic       medir, sel;
    logic [3:0] pul;   // {done_agua, done_xicara, erro_agua, erro_xicara}
    logic [11:0] med;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // water-only measurement, cycle by cycle
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 1'b1, 1'b0, 4'b0000, 12'h000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd2, 1'b0, 1'b0, 4'b0000, 12'h000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd2, 1'b0, 1'b0, 4'b0000, 12'h000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd2, 1'b0, 1'b0, 4'b0000, 12'h000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 12'h0A5, 3'd3, 1'b0, 1'b0, 4'b1000, 12'h0A5};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd5, 1'b0, 1'b0, 4'b0000, 12'h0A5};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd5, 1'b0, 1'b0, 4'b0000, 12'h0A5};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 12'h3FF, 3'd5, 1'b0, 1'b0, 4'b0000, 12'h0A5};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd5, 1'b0, 1'b0, 4'b0000, 12'h0A5};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd5, 1'b0, 1'b0, 4'b0000, 12'h0A5};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0, 4'b0000, 12'h0A5};

    answer = 1'b0; auto_drop = 1'b1; resp_delay = 3;
    clear_log;

    // reset state
    reset = 1'b1;
    req_agua = 1'b0; req_xicara = 1'b0; sensor_pronto = 1'b0; sensor_medida = '0;
    #3 reset = 1'b0;
    tick;
    tick;
    chk("reset_outputs",
        {13'd0, sensor_medir, sensor_sel, medida, done_agua, done_xicara, erro_agua, erro_xicara, ocupado},
        32'd0);
    chk("reset_estado", {29'd0, db_estado}, 32'd0);
    reset = 1'b1;

    // table: water only, pronto 3 cycles after trigger, stray pronto in GUARDA
    for (int i = 0; i < 11; i++) begin
      req_agua      = tbl[i].ra;
      req_xicara    = tbl[i].rx;
      sensor_pronto = tbl[i].pr;
      sensor_medida = tbl[i].mi;
      tick;
      chk($sformatf("v%0d_estado", i), {29'd0, db_estado}, {29'd0, tbl[i].st});
      chk($sformatf("v%0d_medir", i), {31'd0, sensor_medir}, {31'd0, tbl[i].medir});
      chk($sformatf("v%0d_sel", i), {31'd0, sensor_sel}, {31'd0, tbl[i].sel});
      chk($sformatf("v%0d_pulses", i), {28'd0, done_agua, done_xicara, erro_agua, erro_xicara},
          {28'd0, tbl[i].pul});
      chk($sformatf("v%0d_medida", i), {20'd0, medida}, {20'd0, tbl[i].med});
      chk($sformatf("v%0d_ocupado", i), {31'd0, ocupado}, {31'd0, (tbl[i].st != 3'd0)});
    end
    sensor_pronto = 1'b0;

    // both requesters at the first cycle after reset, each answered after 3 cycles
    do_reset;
    clear_log; answer = 1'b1; resp_delay = 3; auto_drop = 1'b1;
    req_agua = 1'b1; req_xicara = 1'b1;
    run(40);
    chk("both_ntrig", n_trig, 2);
    chk("both_first_trig_cyc", trig_cyc[0], 1);
    chk("both_first_sel", {31'd0, trig_sel[0]}, 32'd0);
    chk("both_second_sel", {31'd0, trig_sel[1]}, 32'd1);
    // DISPARA + 3 ESPERA + ENTREGA + GD guard + OCIOSO
    chk("both_spacing", trig_cyc[1] - trig_cyc[0], 1 + 3 + 1 + GD + 1);
    chk("both_done_agua_cyc", da_cyc, trig_cyc[0] + 4);
    chk("both_done_xicara_cyc", dx_cyc, trig_cyc[1] + 4);
    chk("both_order", {31'd0, (da_cyc < dx_cyc)}, 32'd1);
    chk("both_ndone", n_da * 10 + n_dx, 11);
    chk("both_medida", {20'd0, medida}, 32'h155);

    // cup requested, sensor silent: three attempts then erro_xicara
    do_reset;
    clear_log; answer = 1'b0; auto_drop = 1'b1;
    req_xicara = 1'b1;
    run(100);
    chk("silent_ntrig", n_trig, MT);
    for (int i = 0; i < MT; i++) begin
      chk($sformatf("silent_sel%0d", i), {31'd0, trig_sel[i]}, 32'd1);
    end
    for (int i = 1; i < MT; i++) begin
      chk($sformatf("silent_spacing%0d", i), trig_cyc[i] - trig_cyc[i-1], 1 + TO + GD);
    end
    chk("silent_nerro", n_ex, 1);
    chk("silent_erro_cyc", ex_cyc, trig_cyc[MT-1] + TO + 1);
    chk("silent_no_done", n_dx + n_da + n_ea, 0);
    chk("silent_idle", {29'd0, db_estado}, 32'd0);

    // cup requested, pronto on the exact timeout cycle of attempt 1
    do_reset;
    clear_log; answer = 1'b1; resp_delay = TO; auto_drop = 1'b1;
    req_xicara = 1'b1;
    run(60);
    chk("edge_ntrig", n_trig, 1);
    chk("edge_ndone", n_dx, 1);
    chk("edge_done_cyc", dx_cyc, trig_cyc[0] + TO + 1);
    chk("edge_nerro", n_ex, 0);
    chk("edge_medida", {20'd0, medida}, 32'h155);

    // reset while waiting in ESPERA
    do_reset;
    req_agua = 1'b1;
    tick;
    req_agua = 1'b0;
    tick;
    tick;
    chk("rst_pre_estado", {29'd0, db_estado}, 32'd2);
    sensor_pronto = 1'b1;
    sensor_medida = 12'h777;
    reset = 1'b0;
    #2;
    chk("rst_outputs",
        {13'd0, sensor_medir, sensor_sel, medida, done_agua, done_xicara, erro_agua, erro_xicara, ocupado},
        32'd0);
    chk("rst_estado", {29'd0, db_estado}, 32'd0);
    sensor_pronto = 1'b0;
    tick;
    reset = 1'b1;
    clear_log; answer = 1'b1; resp_delay = 3;
    run(40);
    chk("rst_after_quiet", n_trig + n_da + n_dx + n_ea + n_ex, 0);
    chk("rst_after_medida", {20'd0, medida}, 32'd0);

    // both held high for three rounds
    do_reset;
    clear_log; answer = 1'b1; resp_delay = 3; auto_drop = 1'b0;
    req_agua = 1'b1; req_xicara = 1'b1;
    run(30);
    chk("hold_ntrig", {31'd0, (n_trig >= 3)}, 32'd1);
`ifdef CAFETEIRA_ARB_PRIO_AGUA_EN
    chk("hold_sel0", {31'd0, trig_sel[0]}, 32'd0);
    chk("hold_sel1", {31'd0, trig_sel[1]}, 32'd0);
    chk("hold_sel2", {31'd0, trig_sel[2]}, 32'd0);
`else
    chk("hold_sel0", {31'd0, trig_sel[0]}, 32'd0);
    chk("hold_sel1", {31'd0, trig_sel[1]}, 32'd1);
    chk("hold_sel2", {31'd0, trig_sel[2]}, 32'd0);
`endif
    req_agua = 1'b0; req_xicara = 1'b0;
    run(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
